csr_file: RTL and testbench
===========================

Name: csr_file

Overview:
- Machine-mode CSR register file for the RV32 core.
- Responds to CSR accesses: combinational read data, registered writes of the computed new value and write enable.
- Owns trap-entry and MRET state updates, interrupt pending/enable masking, and the trap vector target.
- Sits beside the execute stage; its read data feeds the CSR read-modify-write logic, whose outputs return here.

Parameters:
- HART_ID, 32'h0, value returned by mhartid.
- MTVEC_RESET, 32'h0000_0000, reset value of mtvec.
- MISA_VALUE, 32'h4000_0100, constant returned by misa (RV32I).

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- csr_addr  in  12  CSR address (instr[31:20])
- csr_access  in  1  CSR instruction valid this cycle
- csr_we  in  1  write request (already suppressed for rs1=x0/zimm=0)
- csr_wdata  in  32  new CSR value
- csr_rdata  out  32  current CSR value (combinational)
- csr_illegal  out  1  access illegal (combinational)
- instr_retire  in  1  one instruction retired this cycle
- trap_take  in  1  enter trap this cycle
- trap_cause  in  32  mcause value (bit31 = interrupt)
- trap_pc  in  32  PC saved to mepc
- trap_val  in  32  value saved to mtval
- mret  in  1  MRET executes this cycle
- irq_software  in  1  MSIP source, level
- irq_timer  in  1  MTIP source, level
- irq_external  in  1  MEIP source, level
- trap_vector  out  32  trap target PC (combinational)
- mepc_out  out  32  current mepc, used as the MRET target
- irq_pending  out  1  mstatus.MIE & |(mie & mip)

Behaviour:
- Reads: csr_rdata is combinational from csr_addr.
  - Unimplemented addresses read 0 and assert csr_illegal when csr_access=1.
- Implemented CSRs:
  - mstatus 0x300: only MIE[3] and MPIE[7] are writable; MPP[12:11] reads 2'b11; other bits read 0.
  - misa 0x301: reads MISA_VALUE; writes ignored, legal.
  - mie 0x304: MSIE[3], MTIE[7], MEIE[11] writable; other bits 0.
  - mtvec 0x305: base[31:2] writable. Mode [1:0] WARL: 00 direct, 01 vectored; a written mode of 1x stores 00.
  - mscratch 0x340: full 32-bit.
  - mepc 0x341: bits [1:0] forced to 0.
  - mcause 0x342, mtval 0x343: full 32-bit.
  - mip 0x344: MSIP/MTIP/MEIP reflect the irq inputs directly; writes ignored, legal.
  - mvendorid/marchid/mimpid 0xF11-0xF13 read 0; mhartid 0xF14 reads HART_ID.
- Illegal write: csr_access & csr_we & (csr_addr[11:10]==2'b11) asserts csr_illegal and leaves state unchanged. A read-only CSR accessed with csr_we=0 is legal.
- Writes: commit on the rising clk edge when csr_access & csr_we & ~csr_illegal. The new value is visible on csr_rdata the next cycle.
- Update priority per cycle: trap_take > mret > CSR write. The lower-priority update is dropped entirely.
- Trap entry:
  - mepc <= {trap_pc[31:2],2'b00}; mcause <= trap_cause; mtval <= trap_val.
  - MPIE <= MIE; MIE <= 0.
- mret: MIE <= MPIE; MPIE <= 1.
- trap_vector:
  - Direct mode: {mtvec[31:2],2'b00}.
  - Vectored mode with trap_cause[31]=1: base + 4*trap_cause[4:0].
  - Vectored mode, exceptions: base.
- Reset (async, rst_n low):
  - mstatus reads 32'h0000_1800; mie=0; mtvec=MTVEC_RESET.
  - mscratch, mepc, mcause, mtval = 0; counters = 0.
  - Outputs settle from the reset state: irq_pending=0, mepc_out=0, trap_vector=MTVEC_RESET-derived.
  - Reset mid-access aborts any pending write.

Optional Feature:
- Macro: CSR_COUNTERS_EN.
- Defined: 64-bit mcycle and minstret counters.
  - Addresses: mcycle 0xB00/0xB80(h), minstret 0xB02/0xB82(h); read-only shadows cycle 0xC00/0xC80, instret 0xC02/0xC82.
  - mcycle increments every cycle; minstret increments on instr_retire. Both wrap at 2^64 to 0.
  - A CSR write to either half of a counter replaces that half and suppresses the increment in that cycle.
- Undefined: all these addresses are unimplemented: read 0, csr_illegal on access.

Decomposition:
- csr_pkg:
  - CSR address localparams.
  - mstatus/mie/mip bit indices.
  - mtvec mode encodings.
  - Interrupt cause codes: 3 software, 7 timer, 11 external.
- Sub-module csr_counter64:
  - 64-bit counter with increment enable and separate lo/hi write ports.
  - Instantiated twice under CSR_COUNTERS_EN.

Test Plan:
- Reset then read 0x300, 0x305, 0xF14 -> 32'h0000_1800, MTVEC_RESET, HART_ID; irq_pending=0.
- Write mtvec 32'h8000_0103 -> reads 32'h8000_0100 (mode 1x forced to 00). Write 32'h8000_0101, trap_cause=32'h8000_0007 -> trap_vector=32'h8000_011C.
- Set MIE via mstatus write 32'h8, then trap_take with trap_pc=32'h1236, cause=2 -> mepc=32'h1234, mcause=2, MIE=0, MPIE=1. mret -> MIE=1, MPIE=1.
- mie=32'h80, mstatus.MIE=1, irq_timer=1 -> irq_pending=1 and mip reads 32'h80. Clear mie -> irq_pending=0.
- Write to 0xF11 with csr_we=1 -> csr_illegal=1, no state change. Read 0xF11 with csr_we=0 -> legal, reads 0. Address 0x7C0 -> csr_illegal=1.
- trap_take and mscratch write in the same cycle -> mscratch unchanged. With CSR_COUNTERS_EN: write mcycle=32'hFFFF_FFFF, mcycleh=32'hFFFF_FFFF -> wraps to 0 on the next increment.

Source files
------------

// File: rtl/csr_pkg.sv
// rtl/csr_pkg.sv - CSR addresses, bit indices, mtvec modes and interrupt cause codes
package csr_pkg;

    localparam logic [11:0] CSR_MSTATUS   = 12'h300;
    localparam logic [11:0] CSR_MISA      = 12'h301;
    localparam logic [11:0] CSR_MIE       = 12'h304;
    localparam logic [11:0] CSR_MTVEC     = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
    localparam logic [11:0] CSR_MEPC      = 12'h341;
    localparam logic [11:0] CSR_MCAUSE    = 12'h342;
    localparam logic [11:0] CSR_MTVAL     = 12'h343;
    localparam logic [11:0] CSR_MIP       = 12'h344;
    localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
    localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
    localparam logic [11:0] CSR_CYCLE     = 12'hC00;
    localparam logic [11:0] CSR_INSTRET   = 12'hC02;
    localparam logic [11:0] CSR_CYCLEH    = 12'hC80;
    localparam logic [11:0] CSR_INSTRETH  = 12'hC82;
    localparam logic [11:0] CSR_MVENDORID = 12'hF11;
    localparam logic [11:0] CSR_MARCHID   = 12'hF12;
    localparam logic [11:0] CSR_MIMPID    = 12'hF13;
    localparam logic [11:0] CSR_MHARTID   = 12'hF14;

    localparam int MSTATUS_MIE  = 3;
    localparam int MSTATUS_MPIE = 7;
    localparam int IRQ_MSI      = 3;
    localparam int IRQ_MTI      = 7;
    localparam int IRQ_MEI      = 11;

    typedef enum logic [1:0] {
        MTVEC_DIRECT   = 2'b00,
        MTVEC_VECTORED = 2'b01
    } mtvec_mode_e;

    localparam logic [4:0] CAUSE_MSI = 5'd3;
    localparam logic [4:0] CAUSE_MTI = 5'd7;
    localparam logic [4:0] CAUSE_MEI = 5'd11;

endpackage

// File: rtl/csr_counter64.sv
// rtl/csr_counter64.sv - 64-bit counter with increment enable and lo/hi write ports
module csr_counter64 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        inc,
    input  logic        wr_lo,
    input  logic        wr_hi,
    input  logic [31:0] wdata,
    output logic [63:0] count
);

    // A write to either half takes the cycle; the increment is skipped
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= 64'd0;
        end else if (wr_lo || wr_hi) begin
            if (wr_lo) count[31:0]  <= wdata;
            if (wr_hi) count[63:32] <= wdata;
        end else if (inc) begin
            count <= count + 64'd1;
        end
    end

endmodule

// File: rtl/csr_file.sv
// rtl/csr_file.sv - machine-mode CSR file; mcycle/minstret present when CSR_COUNTERS_EN is defined
module csr_file
    import csr_pkg::*;
#(
    parameter logic [31:0] HART_ID     = 32'h0,
    parameter logic [31:0] MTVEC_RESET = 32'h0000_0000,
    parameter logic [31:0] MISA_VALUE  = 32'h4000_0100
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [11:0] csr_addr,
    input  logic        csr_access,
    input  logic        csr_we,
    input  logic [31:0] csr_wdata,
    output logic [31:0] csr_rdata,
    output logic        csr_illegal,
    input  logic        instr_retire,
    input  logic        trap_take,
    input  logic [31:0] trap_cause,
    input  logic [31:0] trap_pc,
    input  logic [31:0] trap_val,
    input  logic        mret,
    input  logic        irq_software,
    input  logic        irq_timer,
    input  logic        irq_external,
    output logic [31:0] trap_vector,
    output logic [31:0] mepc_out,
    output logic        irq_pending
);

    logic        mstatus_mie, mstatus_mpie;
    logic        mie_msie, mie_mtie, mie_meie;
    logic [29:0] mtvec_base;
    mtvec_mode_e mtvec_mode;
    logic [31:0] mscratch, mcause, mtval;
    logic [29:0] mepc;
    logic [31:0] mstatus_vec, mie_vec, mip_vec, tvec_base;
    logic        implemented, wr_en;

    always_comb begin
        mstatus_vec = 32'h0000_1800;
        mstatus_vec[MSTATUS_MIE]  = mstatus_mie;
        mstatus_vec[MSTATUS_MPIE] = mstatus_mpie;
        mie_vec = 32'd0;
        mie_vec[IRQ_MSI] = mie_msie;
        mie_vec[IRQ_MTI] = mie_mtie;
        mie_vec[IRQ_MEI] = mie_meie;
        mip_vec = 32'd0;
        mip_vec[IRQ_MSI] = irq_software;
        mip_vec[IRQ_MTI] = irq_timer;
        mip_vec[IRQ_MEI] = irq_external;
    end

`ifdef CSR_COUNTERS_EN
    logic [63:0] mcycle, minstret;

    csr_counter64 u_mcycle (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (1'b1),
        .wr_lo (wr_en && csr_addr == CSR_MCYCLE),
        .wr_hi (wr_en && csr_addr == CSR_MCYCLEH),
        .wdata (csr_wdata),
        .count (mcycle)
    );

    csr_counter64 u_minstret (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (instr_retire),
        .wr_lo (wr_en && csr_addr == CSR_MINSTRET),
        .wr_hi (wr_en && csr_addr == CSR_MINSTRETH),
        .wdata (csr_wdata),
        .count (minstret)
    );

    logic [1:0] unused_inputs;
    assign unused_inputs = trap_pc[1:0];
`else
    logic [2:0] unused_inputs;
    assign unused_inputs = {instr_retire, trap_pc[1:0]};
`endif

    always_comb begin
        csr_rdata   = 32'd0;
        implemented = 1'b1;
        case (csr_addr)
            CSR_MSTATUS:   csr_rdata = mstatus_vec;
            CSR_MISA:      csr_rdata = MISA_VALUE;
            CSR_MIE:       csr_rdata = mie_vec;
            CSR_MTVEC:     csr_rdata = {mtvec_base, mtvec_mode};
            CSR_MSCRATCH:  csr_rdata = mscratch;
            CSR_MEPC:      csr_rdata = {mepc, 2'b00};
            CSR_MCAUSE:    csr_rdata = mcause;
            CSR_MTVAL:     csr_rdata = mtval;
            CSR_MIP:       csr_rdata = mip_vec;
            CSR_MVENDORID, CSR_MARCHID, CSR_MIMPID: csr_rdata = 32'd0;
            CSR_MHARTID:   csr_rdata = HART_ID;
`ifdef CSR_COUNTERS_EN
            CSR_MCYCLE,   CSR_CYCLE:    csr_rdata = mcycle[31:0];
            CSR_MCYCLEH,  CSR_CYCLEH:   csr_rdata = mcycle[63:32];
            CSR_MINSTRET, CSR_INSTRET:  csr_rdata = minstret[31:0];
            CSR_MINSTRETH, CSR_INSTRETH: csr_rdata = minstret[63:32];
`endif
            default:       implemented = 1'b0;
        endcase
    end

    // Addresses 0xCxx/0xFxx are read-only by encoding
    assign csr_illegal = csr_access &&
                         (!implemented || (csr_we && csr_addr[11:10] == 2'b11));
    assign wr_en = csr_access && csr_we && !csr_illegal && !trap_take && !mret;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mstatus_mie  <= 1'b0;
            mstatus_mpie <= 1'b0;
            mie_msie     <= 1'b0;
            mie_mtie     <= 1'b0;
            mie_meie     <= 1'b0;
            mtvec_base   <= MTVEC_RESET[31:2];
            mtvec_mode   <= (MTVEC_RESET[1:0] == 2'b01) ? MTVEC_VECTORED : MTVEC_DIRECT;
            mscratch     <= 32'd0;
            mepc         <= 30'd0;
            mcause       <= 32'd0;
            mtval        <= 32'd0;
        end else if (trap_take) begin
            mepc         <= trap_pc[31:2];
            mcause       <= trap_cause;
            mtval        <= trap_val;
            mstatus_mpie <= mstatus_mie;
            mstatus_mie  <= 1'b0;
        end else if (mret) begin
            mstatus_mie  <= mstatus_mpie;
            mstatus_mpie <= 1'b1;
        end else if (wr_en) begin
            case (csr_addr)
                CSR_MSTATUS: begin
                    mstatus_mie  <= csr_wdata[MSTATUS_MIE];
                    mstatus_mpie <= csr_wdata[MSTATUS_MPIE];
                end
                CSR_MIE: begin
                    mie_msie <= csr_wdata[IRQ_MSI];
                    mie_mtie <= csr_wdata[IRQ_MTI];
                    mie_meie <= csr_wdata[IRQ_MEI];
                end
                CSR_MTVEC: begin
                    mtvec_base <= csr_wdata[31:2];
                    mtvec_mode <= (csr_wdata[1:0] == 2'b01) ? MTVEC_VECTORED : MTVEC_DIRECT;
                end
                CSR_MSCRATCH: mscratch <= csr_wdata;
                CSR_MEPC:     mepc     <= csr_wdata[31:2];
                CSR_MCAUSE:   mcause   <= csr_wdata;
                CSR_MTVAL:    mtval    <= csr_wdata;
                default: ;
            endcase
        end
    end

    assign tvec_base   = {mtvec_base, 2'b00};
    assign trap_vector = (mtvec_mode == MTVEC_VECTORED && trap_cause[31])
                         ? tvec_base + {25'd0, trap_cause[4:0], 2'b00}
                         : tvec_base;
    assign mepc_out    = {mepc, 2'b00};
    assign irq_pending = mstatus_mie && |(mie_vec & mip_vec);

endmodule

// File: tb/tb_csr_file.sv
// tb/tb_csr_file.sv - directed vector bench for csr_file
module tb_csr_file;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [11:0] csr_addr = 12'h0;
    logic        csr_access = 1'b0;
    logic        csr_we = 1'b0;
    logic [31:0] csr_wdata = 32'h0;
    logic [31:0] csr_rdata;
    logic        csr_illegal;
    logic        instr_retire = 1'b0;
    logic        trap_take = 1'b0;
    logic [31:0] trap_cause = 32'h0;
    logic [31:0] trap_pc = 32'h0;
    logic [31:0] trap_val = 32'h0;
    logic        mret = 1'b0;
    logic        irq_software = 1'b0;
    logic        irq_timer = 1'b0;
    logic        irq_external = 1'b0;
    logic [31:0] trap_vector;
    logic [31:0] mepc_out;
    logic        irq_pending;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    csr_file dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .csr_addr     (csr_addr),
        .csr_access   (csr_access),
        .csr_we       (csr_we),
        .csr_wdata    (csr_wdata),
        .csr_rdata    (csr_rdata),
        .csr_illegal  (csr_illegal),
        .instr_retire (instr_retire),
        .trap_take    (trap_take),
        .trap_cause   (trap_cause),
        .trap_pc      (trap_pc),
        .trap_val     (trap_val),
        .mret         (mret),
        .irq_software (irq_software),
        .irq_timer    (irq_timer),
        .irq_external (irq_external),
        .trap_vector  (trap_vector),
        .mepc_out     (mepc_out),
        .irq_pending  (irq_pending)
    );

    typedef struct {
        logic [11:0] addr;
        logic        we;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        logic        exp_ill;
    } vec_t;

    vec_t vecs[16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_write(input logic [11:0] addr, input logic [31:0] data);
        @(negedge clk);
        csr_addr = addr; csr_access = 1'b1; csr_we = 1'b1; csr_wdata = data;
        @(negedge clk);
        csr_access = 1'b0; csr_we = 1'b0;
    endtask

    task automatic read_check(input string name, input logic [11:0] addr, input logic [31:0] exp);
        csr_addr = addr; csr_access = 1'b1; csr_we = 1'b0;
        #1;
        check(name, csr_rdata, exp);
        csr_access = 1'b0;
    endtask

    initial begin
        vecs[0]  = '{12'h340, 1'b1, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0};
        vecs[1]  = '{12'h305, 1'b1, 32'h8000_0103, 32'h8000_0100, 1'b0};
        vecs[2]  = '{12'h305, 1'b1, 32'h8000_0101, 32'h8000_0101, 1'b0};
        vecs[3]  = '{12'h341, 1'b1, 32'h0000_1237, 32'h0000_1234, 1'b0};
        vecs[4]  = '{12'h342, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0};
        vecs[5]  = '{12'h343, 1'b1, 32'h1234_5678, 32'h1234_5678, 1'b0};
        vecs[6]  = '{12'h304, 1'b1, 32'hFFFF_FFFF, 32'h0000_0888, 1'b0};
        vecs[7]  = '{12'h300, 1'b1, 32'hFFFF_FFFF, 32'h0000_1888, 1'b0};
        vecs[8]  = '{12'h300, 1'b1, 32'h0000_0000, 32'h0000_1800, 1'b0};
        vecs[9]  = '{12'h301, 1'b1, 32'h0000_0000, 32'h4000_0100, 1'b0};
        vecs[10] = '{12'h344, 1'b1, 32'h0000_0FFF, 32'h0000_0000, 1'b0};
        vecs[11] = '{12'hF11, 1'b1, 32'h0000_0001, 32'h0000_0000, 1'b1};
        vecs[12] = '{12'hF14, 1'b1, 32'h0000_0001, 32'h0000_0000, 1'b1};
        vecs[13] = '{12'h7C0, 1'b0, 32'h0000_0000, 32'h0000_0000, 1'b1};
        vecs[14] = '{12'hF11, 1'b0, 32'h0000_0000, 32'h0000_0000, 1'b0};
        vecs[15] = '{12'h304, 1'b1, 32'h0000_0000, 32'h0000_0000, 1'b0};

        repeat (3) @(negedge clk);
        #1;
        check("rst_irq_pending", {31'd0, irq_pending}, 32'd0);
        check("rst_mepc_out", mepc_out, 32'h0);
        check("rst_trap_vector", trap_vector, 32'h0);
        read_check("rst_mstatus", 12'h300, 32'h0000_1800);
        read_check("rst_mtvec", 12'h305, 32'h0000_0000);
        read_check("rst_mhartid", 12'hF14, 32'h0000_0000);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            csr_addr = vecs[i].addr; csr_access = 1'b1;
            csr_we = vecs[i].we; csr_wdata = vecs[i].wdata;
            #1;
            check($sformatf("vec%0d_illegal", i), {31'd0, csr_illegal}, {31'd0, vecs[i].exp_ill});
            @(negedge clk);
            csr_we = 1'b0;
            #1;
            check($sformatf("vec%0d_rdata", i), csr_rdata, vecs[i].exp_rd);
            csr_access = 1'b0;
        end

        // mtvec is now vectored at 0x8000_0100
        trap_cause = 32'h8000_0007;
        #1;
        check("tvec_vectored_irq", trap_vector, 32'h8000_011C);
        trap_cause = 32'h0000_0002;
        #1;
        check("tvec_vectored_exc", trap_vector, 32'h8000_0100);

        do_write(12'h300, 32'h0000_0008);
        read_check("mstatus_mie_set", 12'h300, 32'h0000_1808);

        // trap entry with a competing mscratch write
        @(negedge clk);
        trap_take = 1'b1; trap_pc = 32'h0000_1236; trap_cause = 32'h2; trap_val = 32'h0000_0ABC;
        csr_addr = 12'h340; csr_access = 1'b1; csr_we = 1'b1; csr_wdata = 32'h5555_5555;
        @(negedge clk);
        trap_take = 1'b0; csr_we = 1'b0; csr_access = 1'b0;
        #1;
        check("trap_mepc_out", mepc_out, 32'h0000_1234);
        read_check("trap_mcause", 12'h342, 32'h0000_0002);
        read_check("trap_mtval", 12'h343, 32'h0000_0ABC);
        read_check("trap_mstatus", 12'h300, 32'h0000_1880);
        read_check("trap_mscratch_kept", 12'h340, 32'hDEAD_BEEF);

        // mret with a competing mstatus write
        @(negedge clk);
        mret = 1'b1;
        csr_addr = 12'h300; csr_access = 1'b1; csr_we = 1'b1; csr_wdata = 32'h0;
        @(negedge clk);
        mret = 1'b0; csr_we = 1'b0; csr_access = 1'b0;
        read_check("mret_mstatus", 12'h300, 32'h0000_1888);

        do_write(12'h304, 32'h0000_0080);
        irq_timer = 1'b1;
        #1;
        check("irq_pending_on", {31'd0, irq_pending}, 32'd1);
        read_check("mip_timer", 12'h344, 32'h0000_0080);
        do_write(12'h304, 32'h0000_0000);
        #1;
        check("irq_pending_off", {31'd0, irq_pending}, 32'd0);
        irq_timer = 1'b0;

`ifdef CSR_COUNTERS_EN
        @(negedge clk);
        csr_addr = 12'hB00; csr_access = 1'b1; csr_we = 1'b1; csr_wdata = 32'hFFFF_FFFF;
        @(negedge clk);
        csr_addr = 12'hB80;
        @(negedge clk);
        csr_we = 1'b0; csr_access = 1'b0;
        read_check("mcycle_lo_written", 12'hB00, 32'hFFFF_FFFF);
        read_check("mcycle_hi_written", 12'hB80, 32'hFFFF_FFFF);
        @(posedge clk);
        #1;
        read_check("mcycle_lo_wrap", 12'hB00, 32'h0);
        read_check("cycleh_wrap", 12'hC80, 32'h0);
`else
        csr_addr = 12'hB00; csr_access = 1'b1; csr_we = 1'b0;
        #1;
        check("mcycle_absent_illegal", {31'd0, csr_illegal}, 32'd1);
        csr_access = 1'b0;
`endif

        // reset asserted while a write is being presented
        @(negedge clk);
        csr_addr = 12'h340; csr_access = 1'b1; csr_we = 1'b1; csr_wdata = 32'h0000_0001;
        #2 rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        csr_we = 1'b0; csr_access = 1'b0;
        rst_n = 1'b1;
        read_check("rst_mid_mscratch", 12'h340, 32'h0);
        read_check("rst_mid_mstatus", 12'h300, 32'h0000_1800);
        check("rst_mid_mepc_out", mepc_out, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
